// File: rtl/ge_p1p1_convert_seq_if.sv
// Interface bundling the caller request/result signals and the shared fe_mul port
// of ge_p1p1_convert_seq. The slave modport is the sequencer; master is its
// environment (caller plus multiplier).
interface ge_p1p1_convert_seq_if #(
  parameter int W = 320
);
  // Caller request
  logic                start;
  logic                mode;
  logic signed [W-1:0] p_X;
  logic signed [W-1:0] p_Y;
  logic signed [W-1:0] p_Z;
  logic signed [W-1:0] p_T;
  // Caller status and results
  logic                busy;
  logic                done;
  logic                err;
  logic signed [W-1:0] r_X;
  logic signed [W-1:0] r_Y;
  logic signed [W-1:0] r_Z;
  logic signed [W-1:0] r_T;
  // Shared multiplier port
  logic                mul_start;
  logic signed [W-1:0] mul_f;
  logic signed [W-1:0] mul_g;
  logic                mul_done;
  logic signed [W-1:0] mul_h;

  modport slave (
    input  start, mode, p_X, p_Y, p_Z, p_T, mul_done, mul_h,
    output busy, done, err, r_X, r_Y, r_Z, r_T, mul_start, mul_f, mul_g
  );

  modport master (
    output start, mode, p_X, p_Y, p_Z, p_T, mul_done, mul_h,
    input  busy, done, err, r_X, r_Y, r_Z, r_T, mul_start, mul_f, mul_g
  );
endinterface

// File: rtl/ge_p1p1_convert_seq.sv
// ge_p1p1 -> ge_p2 / ge_p3 conversion sequencer.
// Issues 3 (mode=0) or 4 (mode=1) products to a shared external fe_mul:
//   op0 r_X = X*T, op1 r_Y = Y*Z, op2 r_Z = Z*T, op3 r_T = X*Y.
// Operands are latched on accept so the caller may change p_* while busy.
// Optional build macro GE_CONV_TIMEOUT_EN adds a per-product watchdog that
// aborts to DONE with err=1 after TIMEOUT_CYCLES cycles without mul_done.
module ge_p1p1_convert_seq #(
  parameter int LIMBS          = 10,
  parameter int LIMB_W         = 32,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input logic                    clk,
  input logic                    reset,
  ge_p1p1_convert_seq_if.slave   bus
);

  localparam int W = LIMBS * LIMB_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [1:0]          r_op;
  logic                r_mode;
  logic signed [W-1:0] r_px, r_py, r_pz, r_pt;
  logic signed [W-1:0] r_res_x, r_res_y, r_res_z, r_res_t;
  logic signed [W-1:0] w_mul_f, w_mul_g;
  logic                w_last_op;
  logic                w_timeout;

  // Last product is op2 for ge_p2 and op3 for ge_p3.
  assign w_last_op = r_mode ? (r_op == 2'd3) : (r_op == 2'd2);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic.
  // NOTE: default assigned first so no path leaves w_next_state unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_next_state = S_ISSUE;
      S_ISSUE: w_next_state = S_WAIT;
      S_WAIT: begin
        if (bus.mul_done)   w_next_state = w_last_op ? S_DONE : S_ISSUE;
        else if (w_timeout) w_next_state = S_DONE;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Operand latch, op index and result registers.
  // NOTE: the wide datapath registers are reset too, because reset values are observable outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op    <= '0;
      r_mode  <= 1'b0;
      r_px    <= '0;
      r_py    <= '0;
      r_pz    <= '0;
      r_pt    <= '0;
      r_res_x <= '0;
      r_res_y <= '0;
      r_res_z <= '0;
      r_res_t <= '0;
    end else begin
      if (r_state == S_IDLE && bus.start) begin
        r_op   <= '0;
        r_mode <= bus.mode;
        r_px   <= bus.p_X;
        r_py   <= bus.p_Y;
        r_pz   <= bus.p_Z;
        r_pt   <= bus.p_T;
      end
      if (r_state == S_WAIT && bus.mul_done) begin
        unique case (r_op)
          2'd0: r_res_x <= bus.mul_h;
          2'd1: r_res_y <= bus.mul_h;
          2'd2: r_res_z <= bus.mul_h;
          2'd3: r_res_t <= bus.mul_h;
          default: ;
        endcase
        if (!w_last_op) r_op <= r_op + 2'd1;
      end
    end
  end

  // Operand select for the current op; held stable because r_op and the latched
  // operands only change on accept or on mul_done.
  always_comb begin
    w_mul_f = r_px;
    w_mul_g = r_pt;
    unique case (r_op)
      2'd1: begin w_mul_f = r_py; w_mul_g = r_pz; end
      2'd2: begin w_mul_f = r_pz; w_mul_g = r_pt; end
      2'd3: begin w_mul_f = r_px; w_mul_g = r_py; end
      default: ;
    endcase
  end

`ifdef GE_CONV_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_tmo_cnt;
  logic             r_err;

  assign w_timeout = (r_state == S_WAIT) && (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES));

  // Watchdog counter (cleared per product) and sticky-until-accept error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      if (r_state == S_ISSUE)
        r_tmo_cnt <= '0;
      else if (r_state == S_WAIT && !bus.mul_done && !w_timeout)
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      if (r_state == S_IDLE && bus.start)
        r_err <= 1'b0;
      else if (r_state == S_WAIT && !bus.mul_done && w_timeout)
        r_err <= 1'b1;
    end
  end

  assign bus.err = r_err;
`else
  assign w_timeout = 1'b0;
  assign bus.err   = 1'b0;
`endif

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.mul_start = (r_state == S_ISSUE);
  assign bus.mul_f     = w_mul_f;
  assign bus.mul_g     = w_mul_g;
  assign bus.r_X       = r_res_x;
  assign bus.r_Y       = r_res_y;
  assign bus.r_Z       = r_res_z;
  assign bus.r_T       = r_res_t;

endmodule

// File: tb/tb_ge_p1p1_convert_seq.sv
// Scoreboard bench for ge_p1p1_convert_seq: stimulus pushes expected results,
// a done-triggered monitor pops and compares. fe_mul is modelled as h=f*g
// truncated to W bits with latency L.
module tb_ge_p1p1_convert_seq;

  localparam int LIMBS  = 10;
  localparam int LIMB_W = 32;
  localparam int W      = LIMBS * LIMB_W;
  localparam int L      = 3;
`ifdef GE_CONV_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 1023;
`endif

  typedef logic signed [W-1:0] fe_t;
  typedef struct {
    fe_t  x, y, z, t;
    logic err;
    int   done_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   cyc     = 0;
  int   n_done  = 0;
  int   n_issue = 0;
  int   drop_at = -1;
  int   done_before;
  int   model_idx;
  fe_t  model_h;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic m_done_model = 1'b0;
  logic m_done_force = 1'b0;

  ge_p1p1_convert_seq_if #(.W(W)) bus ();

  ge_p1p1_convert_seq #(
    .LIMBS          (LIMBS),
    .LIMB_W         (LIMB_W),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.mul_done = m_done_model | m_done_force;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input fe_t act, input fe_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      fe_t'(bus.busy),      '0);
    check({tag, "_done"},      fe_t'(bus.done),      '0);
    check({tag, "_err"},       fe_t'(bus.err),       '0);
    check({tag, "_mul_start"}, fe_t'(bus.mul_start), '0);
    check({tag, "_mul_f"},     bus.mul_f,            '0);
    check({tag, "_mul_g"},     bus.mul_g,            '0);
    check({tag, "_r_X"},       bus.r_X,              '0);
    check({tag, "_r_Y"},       bus.r_Y,              '0);
    check({tag, "_r_Z"},       bus.r_Z,              '0);
    check({tag, "_r_T"},       bus.r_T,              '0);
  endtask

  task automatic expect_run(input fe_t ex, ey, ez, et, input logic eerr, input int nops);
    exp_t e;
    e.x = ex; e.y = ey; e.z = ez; e.t = et; e.err = eerr;
    e.done_cyc = cyc + nops * (L + 1) + 1;
    sb.push_back(e);
  endtask

  // Called #1 after a rising edge; returns #1 after the next edge (ISSUE cycle).
  task automatic launch(input logic m, input fe_t x, y, z, t);
    bus.mode  = m;
    bus.p_X   = x;
    bus.p_Y   = y;
    bus.p_Z   = z;
    bus.p_T   = t;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((bus.busy || sb.size() != 0) && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= budget) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_idle: still busy after %0d cycles, expected idle", budget);
    end
  endtask

  // fe_mul model: mul_done L cycles after the mul_start cycle.
  initial begin
    bus.mul_h = '0;
    forever begin
      @(negedge clk);
      if (bus.mul_start && !reset) begin
        model_h   = bus.mul_f * bus.mul_g;
        model_idx = n_issue;
        n_issue++;
        if (model_idx != drop_at) begin
          repeat (L) @(posedge clk);
          #1;
          bus.mul_h    = model_h;
          m_done_model = 1'b1;
          @(posedge clk); #1;
          m_done_model = 1'b0;
        end
      end
    end
  end

  // Monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      n_done++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: done at cycle %0d, expected no done", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("r_X",        bus.r_X,          mon_e.x);
        check("r_Y",        bus.r_Y,          mon_e.y);
        check("r_Z",        bus.r_Z,          mon_e.z);
        check("r_T",        bus.r_T,          mon_e.t);
        check("err",        fe_t'(bus.err),   fe_t'(mon_e.err));
        check("done_cycle", fe_t'(cyc),       fe_t'(mon_e.done_cyc));
        check("busy_at_done", fe_t'(bus.busy), fe_t'(1));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    bus.p_X   = '0;
    bus.p_Y   = '0;
    bus.p_Z   = '0;
    bus.p_T   = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_all_zero("reset");

    // ge_p3 conversion, done at cycle 17.
    expect_run(14, 15, 35, 6, 1'b0, 4);
    launch(1'b1, 2, 3, 5, 7);
    wait_idle(100);

    // Preload r_T=99, then ge_p2 conversion leaves it untouched, done at cycle 13.
    expect_run(9, 11, 1, 99, 1'b0, 4);
    launch(1'b1, 9, 11, 1, 1);
    wait_idle(100);
    expect_run(14, 15, 35, 99, 1'b0, 3);
    launch(1'b0, 2, 3, 5, 7);
    wait_idle(100);

    // Signed operands and W-bit wraparound: (-1)*5, 2^319*2 -> 0, 2*5.
    expect_run(-5, 0, 10, 99, 1'b0, 3);
    launch(1'b0, -1, fe_t'(1) << 319, 2, 5);
    wait_idle(100);

    // Inputs changed and start pulsed at cycle 5: latched run only, one done.
    done_before = n_done;
    expect_run(14, 15, 35, 6, 1'b0, 4);
    launch(1'b1, 2, 3, 5, 7);
    repeat (4) begin @(posedge clk); #1; end
    bus.mode = 1'b0;
    bus.p_X = 100; bus.p_Y = 200; bus.p_Z = 300; bus.p_T = 400;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_idle(100);
    repeat (20) begin @(posedge clk); #1; end
    check("no_second_run_busy", fe_t'(bus.busy), '0);
    check("single_done_pulse", fe_t'(n_done - done_before), 1);

    // Spurious mul_done in IDLE: nothing changes.
    m_done_force = 1'b1;
    @(posedge clk); #1;
    m_done_force = 1'b0;
    @(posedge clk); #1;
    check("idle_spur_busy", fe_t'(bus.busy), '0);
    check("idle_spur_r_X", bus.r_X, 14);
    check("idle_spur_r_Y", bus.r_Y, 15);
    check("idle_spur_r_Z", bus.r_Z, 35);
    check("idle_spur_r_T", bus.r_T, 6);

    // Spurious mul_done in ISSUE: op index and timing unaffected.
    expect_run(6, 10, 15, 4, 1'b0, 4);
    launch(1'b1, 2, 2, 5, 3);
    check("in_issue_state", fe_t'(bus.mul_start), 1);
    m_done_force = 1'b1;
    @(posedge clk); #1;
    m_done_force = 1'b0;
    wait_idle(100);

    // Reset at cycle 8, stray mul_done at cycle 9, then a normal run.
    launch(1'b1, 2, 3, 5, 7);
    repeat (7) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1 m_done_force = 1'b1;
    check_all_zero("abort");
    @(posedge clk); #1;
    m_done_force = 1'b0;
    check_all_zero("post_abort");
    expect_run(14, 15, 35, 6, 1'b0, 4);
    launch(1'b1, 2, 3, 5, 7);
    wait_idle(100);

`ifdef GE_CONV_TIMEOUT_EN
    // op1 never completes: r_X written, abort with err at 1+4+1+8+1 = 15.
    drop_at = n_issue + 1;
    begin
      exp_t e;
      e.x = 28; e.y = 15; e.z = 35; e.t = 6; e.err = 1'b1;
      e.done_cyc = cyc + 15;
      sb.push_back(e);
    end
    launch(1'b1, 4, 3, 5, 7);
    wait_idle(100);
    // Next accept clears err.
    expect_run(14, 15, 35, 6, 1'b0, 4);
    launch(1'b1, 2, 3, 5, 7);
    wait_idle(100);
`endif

    repeat (5) begin @(posedge clk); #1; end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
